// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start/busy/done handshake wraps it, and a sticky flag reports values too large for DIGITS digits.

module bcd_digit_cell (
    input  logic [3:0] digit,
    input  logic       carry_in,
    output logic [3:0] digit_next,
    output logic       carry_out
);

    logic [3:0] adj;

    // Adding 3 at >=5 makes the following doubling carry at exactly 10.
    always_comb begin
        adj = digit;
        if (digit >= 4'd5)
            adj = digit + 4'd3;
    end

    assign digit_next = {adj[2:0], carry_in};
    assign carry_out  = adj[3];

endmodule

module bin_to_bcd_seq #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        bin_sr;
    logic [DIGITS-1:0][3:0]  work, work_next;
    logic [DIGITS:0]         carry;
    logic                    ovf_acc;
    logic                    accept;
    logic                    last_iter;

    // The binary MSB feeds the units digit; each digit's top bit ripples into the next.
    assign carry[0] = bin_sr[WIDTH-1];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .digit      (work[g]),
                .carry_in   (carry[g]),
                .digit_next (work_next[g]),
                .carry_out  (carry[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Published bcd/ovf change only on the final iteration, never on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bin_sr  <= '0;
            work    <= '0;
            ovf_acc <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= last_iter;
            if (accept) begin
                bin_sr  <= bin;
                work    <= '0;
                ovf_acc <= 1'b0;
                cnt     <= CNT_W'(WIDTH);
            end else if (state == CONV) begin
                bin_sr  <= bin_sr << 1;
                work    <= work_next;
                ovf_acc <= ovf_acc | carry[DIGITS];
                cnt     <= cnt - CNT_W'(1);
                if (last_iter) begin
                    bcd <= work_next;
                    ovf <= ovf_acc | carry[DIGITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: four parameterisations driven by directed and random conversions,
// with every result compared against a decimal-arithmetic reference.

module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic [3:0]  starts;
    logic [7:0]  bin_all;

    logic        a_busy, a_done, a_ovf;
    logic [7:0]  a_bcd;
    logic        b_busy, b_done, b_ovf;
    logic [11:0] b_bcd;
    logic        c_busy, c_done, c_ovf;
    logic [7:0]  c_bcd;
    logic        d_busy, d_done, d_ovf;
    logic [3:0]  d_bcd;

    int          sel;
    logic        o_busy, o_done, o_ovf;
    logic [11:0] o_bcd;
    logic [11:0] last_bcd [4];
    int          errors;
    int          checks;

    bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2)) dut_a (
        .clk(clk), .reset(reset), .start(starts[0]), .bin(bin_all[5:0]),
        .busy(a_busy), .done(a_done), .bcd(a_bcd), .ovf(a_ovf));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_b (
        .clk(clk), .reset(reset), .start(starts[1]), .bin(bin_all),
        .busy(b_busy), .done(b_done), .bcd(b_bcd), .ovf(b_ovf));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_c (
        .clk(clk), .reset(reset), .start(starts[2]), .bin(bin_all),
        .busy(c_busy), .done(c_done), .bcd(c_bcd), .ovf(c_ovf));

    bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) dut_d (
        .clk(clk), .reset(reset), .start(starts[3]), .bin(bin_all[0:0]),
        .busy(d_busy), .done(d_done), .bcd(d_bcd), .ovf(d_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_ovf  = 1'b0;
        o_bcd  = '0;
        case (sel)
            0: begin o_busy = a_busy; o_done = a_done; o_ovf = a_ovf; o_bcd = {4'h0, a_bcd}; end
            1: begin o_busy = b_busy; o_done = b_done; o_ovf = b_ovf; o_bcd = b_bcd; end
            2: begin o_busy = c_busy; o_done = c_done; o_ovf = c_ovf; o_bcd = {4'h0, c_bcd}; end
            default: begin o_busy = d_busy; o_done = d_done; o_ovf = d_ovf; o_bcd = {8'h0, d_bcd}; end
        endcase
    end

    function automatic int sel_width(input int s);
        return (s == 0) ? 6 : (s == 3) ? 1 : 8;
    endfunction

    function automatic int sel_digits(input int s);
        return (s == 1) ? 3 : (s == 3) ? 1 : 2;
    endfunction

    // Decimal reference: digit k is (v / 10^k) % 10, so truncation on overflow falls out naturally.
    function automatic logic [11:0] model_bcd(input int v, input int digits);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int v, input int digits);
        int p;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        return (v >= p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in a cycle where the selected DUT is idle (possibly its done cycle); returns in the done cycle.
    task automatic convert(input int v);
        int w, d, lat;
        logic [11:0] exp_bcd;
        w = sel_width(sel);
        d = sel_digits(sel);
        exp_bcd = model_bcd(v, d);
        starts[sel] = 1'b1;
        bin_all = 8'(v);
        tick();
        starts = '0;
        bin_all = 8'($urandom);
        chk($sformatf("busy_after_accept[s%0d v%0d]", sel, v), 32'(o_busy), 32'd1);
        chk($sformatf("hold_after_accept[s%0d v%0d]", sel, v), 32'(o_bcd), 32'(last_bcd[sel]));
        lat = 0;
        do begin
            tick();
            lat++;
        end while (o_done !== 1'b1 && lat < 40);
        chk($sformatf("latency[s%0d v%0d]", sel, v), lat, w);
        chk($sformatf("bcd[s%0d v%0d]", sel, v), 32'(o_bcd), 32'(exp_bcd));
        chk($sformatf("ovf[s%0d v%0d]", sel, v), 32'(o_ovf), 32'(model_ovf(v, d)));
        chk($sformatf("busy_in_done[s%0d v%0d]", sel, v), 32'(o_busy), 32'd0);
        last_bcd[sel] = exp_bcd;
    endtask

    initial begin
        int ndone;
        errors  = 0;
        checks  = 0;
        sel     = 0;
        starts  = '0;
        bin_all = '0;
        reset   = 1'b1;
        for (int s = 0; s < 4; s++) last_bcd[s] = '0;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_busy[s%0d]", s), 32'(o_busy), 32'd0);
            chk($sformatf("reset_done[s%0d]", s), 32'(o_done), 32'd0);
            chk($sformatf("reset_bcd[s%0d]", s), 32'(o_bcd), 32'd0);
            chk($sformatf("reset_ovf[s%0d]", s), 32'(o_ovf), 32'd0);
        end
        reset = 1'b0;
        sel = 0;
        tick();

        // bin=0 runs the full length; done is a single-cycle pulse.
        convert(0);
        tick();
        chk("done_one_cycle", 32'(o_done), 32'd0);
        chk("idle_after_done", 32'(o_busy), 32'd0);

        // Back-to-back sweep: each accept lands in the previous done cycle.
        for (int v = 0; v < 64; v++) begin
            convert(v);
            if (v == 39) chk("sweep_39", 32'(o_bcd), 32'h39);
            if (v == 40) chk("sweep_40", 32'(o_bcd), 32'h40);
            if (v == 63) chk("sweep_63", 32'(o_bcd), 32'h63);
        end
        for (int i = 0; i < 10; i++) convert(int'($urandom_range(0, 63)));
        tick();

        // start while busy is ignored.
        starts[0] = 1'b1;
        bin_all = 8'd45;
        tick();
        starts = '0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 5) chk($sformatf("busy_hold[%0d]", k), 32'(o_busy), 32'd1);
            if (o_done === 1'b1) ndone++;
            starts[0] = (k <= 3);
            bin_all = (k <= 3) ? 8'd12 : 8'd0;
        end
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_bcd", 32'(o_bcd), 32'h45);
        chk("ignored_start_idle", 32'(o_busy), 32'd0);
        last_bcd[0] = 12'h045;

        // Reset mid-conversion discards the in-flight value.
        starts[0] = 1'b1;
        bin_all = 8'd57;
        tick();
        starts = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_busy", 32'(o_busy), 32'd0);
        chk("midreset_done", 32'(o_done), 32'd0);
        chk("midreset_bcd", 32'(o_bcd), 32'd0);
        chk("midreset_ovf", 32'(o_ovf), 32'd0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_done === 1'b1) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        for (int s = 0; s < 4; s++) last_bcd[s] = '0;
        convert(21);
        chk("after_reset_21", 32'(o_bcd), 32'h21);
        tick();

        // Three digits, eight bits.
        sel = 1;
        convert(255);
        chk("w8d3_255", 32'(o_bcd), 32'h255);
        convert(100);
        chk("w8d3_100", 32'(o_bcd), 32'h100);
        for (int i = 0; i < 15; i++) convert(int'($urandom_range(0, 255)));
        tick();

        // Two digits, eight bits: overflow truncates and clears per conversion.
        sel = 2;
        convert(255);
        chk("w8d2_255_bcd", 32'(o_bcd), 32'h55);
        chk("w8d2_255_ovf", 32'(o_ovf), 32'd1);
        convert(99);
        chk("w8d2_99_bcd", 32'(o_bcd), 32'h99);
        chk("w8d2_99_ovf", 32'(o_ovf), 32'd0);
        convert(100);
        chk("w8d2_100_ovf", 32'(o_ovf), 32'd1);
        for (int i = 0; i < 15; i++) convert(int'($urandom_range(0, 255)));
        tick();

        // Single-bit input: one iteration.
        sel = 3;
        convert(1);
        convert(0);
        convert(1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
